// File: rtl/seg_capture.sv
// Seven-segment bus receiver: recovers per-digit values from the multiplexed active-low
// anode/segment lines once a pattern has been stable for STABLE_CYCLES synchronised samples.
module seg_capture #(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic        fclk,
    input  logic        rst_n,
    input  logic [3:0]  anode,
    input  logic [6:0]  segOut,
    output logic [15:0] digVal,
    output logic [3:0]  digBlank,
    output logic [3:0]  digErr,
    output logic        frameDone,
    output logic        anodeErr
);

    localparam logic [7:0] StableMax = 8'(STABLE_CYCLES);

    typedef enum logic [1:0] {StWait, StSettle, StHeld} state_e;

    // Input path: {anode, segOut}; all-ones means nothing selected, all segments off.
    logic [10:0] sync1_q, sync1_d;
    logic [10:0] sync2_q, sync2_d;
    logic [10:0] prev_q, prev_d;
    logic [7:0]  cnt_q, cnt_d;
    state_e      state_q, state_d;

    logic [15:0] dig_val_q, dig_val_d;
    logic [3:0]  dig_blank_q, dig_blank_d;
    logic [3:0]  dig_err_q, dig_err_d;
    logic [3:0]  seen_q, seen_d;
    logic        frame_done_q, frame_done_d;
    logic        anode_err_q, anode_err_d;

    logic        changed;
    logic        eval_en;
    logic [2:0]  low_cnt;
    logic [1:0]  dig_idx;
    logic [3:0]  dec_val;
    logic        dec_valid;
    logic        dec_blank;
    logic [3:0]  seen_next;

    assign changed = (sync2_q != prev_q);

    always_comb begin
        sync1_d = {anode, segOut};
        sync2_d = sync1_q;
        prev_d  = sync2_q;
        if (changed) begin
            cnt_d = 8'd0;
        end else if (cnt_q < StableMax) begin
            cnt_d = cnt_q + 8'd1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // FSM: state register
    always_ff @(posedge fclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StWait;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StWait: begin
                if (!changed) begin
                    state_d = StSettle;
                end
            end
            StSettle: begin
                if (changed) begin
                    state_d = StWait;
                end else if (cnt_d == StableMax) begin
                    state_d = StHeld;
                end
            end
            StHeld: begin
                if (changed) begin
                    state_d = StWait;
                end
            end
            default: state_d = StWait;
        endcase
    end

    // FSM: outputs; evaluation fires on the edge the counter reaches its target.
    always_comb begin
        eval_en = 1'b0;
        unique case (state_q)
            StSettle: eval_en = !changed && (cnt_d == StableMax);
            default:  eval_en = 1'b0;
        endcase
    end

    always_comb begin
        low_cnt = 3'd0;
        dig_idx = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (!sync2_q[7 + i]) begin
                low_cnt = low_cnt + 3'd1;
                dig_idx = 2'(i);
            end
        end
    end

    always_comb begin
        dec_val   = 4'd0;
        dec_valid = 1'b1;
        dec_blank = 1'b0;
        case (sync2_q[6:0])
            7'h40: dec_val = 4'd0;
            7'h79: dec_val = 4'd1;
            7'h24: dec_val = 4'd2;
            7'h30: dec_val = 4'd3;
            7'h19: dec_val = 4'd4;
            7'h12: dec_val = 4'd5;
            7'h02: dec_val = 4'd6;
            7'h78: dec_val = 4'd7;
            7'h00: dec_val = 4'd8;
            7'h10: dec_val = 4'd9;
            7'h7F: begin
                dec_valid = 1'b0;
                dec_blank = 1'b1;
            end
            default: dec_valid = 1'b0;
        endcase
    end

    always_comb begin
        dig_val_d    = dig_val_q;
        dig_blank_d  = dig_blank_q;
        dig_err_d    = dig_err_q;
        seen_d       = seen_q;
        frame_done_d = 1'b0;
        anode_err_d  = 1'b0;
        seen_next    = seen_q | (4'b0001 << dig_idx);
        if (eval_en) begin
            if (low_cnt == 3'd1) begin
                if (dec_valid) begin
                    dig_val_d[{dig_idx, 2'b00} +: 4] = dec_val;
                    dig_blank_d[dig_idx] = 1'b0;
                    dig_err_d[dig_idx]   = 1'b0;
                end else if (dec_blank) begin
                    dig_blank_d[dig_idx] = 1'b1;
                    dig_err_d[dig_idx]   = 1'b0;
                end else begin
                    dig_blank_d[dig_idx] = 1'b0;
                    dig_err_d[dig_idx]   = 1'b1;
                end
                if (seen_next == 4'hF) begin
                    frame_done_d = 1'b1;
                    seen_d       = 4'h0;
                end else begin
                    seen_d = seen_next;
                end
            end else if (low_cnt >= 3'd2) begin
                anode_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge fclk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q      <= '1;
            sync2_q      <= '1;
            prev_q       <= '1;
            cnt_q        <= 8'd0;
            dig_val_q    <= 16'h0000;
            dig_blank_q  <= 4'h0;
            dig_err_q    <= 4'h0;
            seen_q       <= 4'h0;
            frame_done_q <= 1'b0;
            anode_err_q  <= 1'b0;
        end else begin
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            prev_q       <= prev_d;
            cnt_q        <= cnt_d;
            dig_val_q    <= dig_val_d;
            dig_blank_q  <= dig_blank_d;
            dig_err_q    <= dig_err_d;
            seen_q       <= seen_d;
            frame_done_q <= frame_done_d;
            anode_err_q  <= anode_err_d;
        end
    end

    assign digVal    = dig_val_q;
    assign digBlank  = dig_blank_q;
    assign digErr    = dig_err_q;
    assign frameDone = frame_done_q;
    assign anodeErr  = anode_err_q;

endmodule

// File: tb/tb_seg_capture.sv
// Bench for seg_capture: directed scenarios followed by random segment streams checked
// against a per-hold-period reference model.
module tb_seg_capture;

    localparam int unsigned STABLE = 4;

    logic        fclk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  anode = 4'b1110;
    logic [6:0]  segOut = 7'h79;
    logic [15:0] digVal;
    logic [3:0]  digBlank;
    logic [3:0]  digErr;
    logic        frameDone;
    logic        anodeErr;

    seg_capture #(.STABLE_CYCLES(STABLE)) dut (
        .fclk      (fclk),
        .rst_n     (rst_n),
        .anode     (anode),
        .segOut    (segOut),
        .digVal    (digVal),
        .digBlank  (digBlank),
        .digErr    (digErr),
        .frameDone (frameDone),
        .anodeErr  (anodeErr)
    );

    always #5 fclk = ~fclk;

    int n_checks = 0;
    int n_errors = 0;
    int fd_cnt = 0;
    int ae_cnt = 0;
    int both_cnt = 0;

    always @(negedge fclk) begin
        if (frameDone) fd_cnt <= fd_cnt + 1;
        if (anodeErr) ae_cnt <= ae_cnt + 1;
        if (frameDone && anodeErr) both_cnt <= both_cnt + 1;
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive a pattern for n rising edges; returns 1 time unit after the last edge.
    task automatic hold(input logic [3:0] a, input logic [6:0] s, input int n);
        anode  = a;
        segOut = s;
        repeat (n) @(posedge fclk);
        #1;
    endtask

    // Reference model: one entry per hold period of the raw inputs.
    logic [6:0] pat_tbl [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    logic [3:0] m_val [4];
    logic [3:0] m_blank, m_err;
    logic [3:0] m_seen;
    int         m_fd, m_ae;

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_val[i] = 4'h0;
        m_blank = 4'h0;
        m_err   = 4'h0;
        m_seen  = 4'h0;
        m_fd    = 0;
        m_ae    = 0;
    endtask

    // A hold of len edges gives len-1 unchanged synchronised samples.
    task automatic model_seg(input logic [3:0] a, input logic [6:0] s, input int len);
        int nlow;
        int idx;
        int val;
        if (len < int'(STABLE) + 1) return;
        nlow = 4 - $countones(a);
        if (nlow == 0) return;
        if (nlow > 1) begin
            m_ae++;
            return;
        end
        idx = 0;
        for (int i = 0; i < 4; i++) if (!a[i]) idx = i;
        val = -1;
        for (int k = 0; k < 10; k++) if (pat_tbl[k] == s) val = k;
        if (val >= 0) begin
            m_val[idx] = 4'(val);
            m_blank[idx] = 1'b0;
            m_err[idx] = 1'b0;
        end else if (s == 7'h7F) begin
            m_blank[idx] = 1'b1;
            m_err[idx] = 1'b0;
        end else begin
            m_blank[idx] = 1'b0;
            m_err[idx] = 1'b1;
        end
        m_seen[idx] = 1'b1;
        if (m_seen == 4'hF) begin
            m_fd++;
            m_seen = 4'h0;
        end
    endtask

    initial begin
        int fd0, ae0, bad;
        logic [3:0] a, pa;
        logic [6:0] s, ps;
        int len, r;

        // Reset holds everything at zero even with a valid digit on the bus.
        repeat (3) @(posedge fclk);
        #1;
        chk("reset_digVal", digVal, 16'h0000);
        chk("reset_digBlank", 16'(digBlank), 16'h0);
        chk("reset_digErr", 16'(digErr), 16'h0);
        chk("reset_pulses", 16'({frameDone, anodeErr}), 16'h0);
        rst_n = 1'b1;
        repeat (STABLE + 2) @(posedge fclk);
        #1;
        chk("latency_before", digVal, 16'h0000);
        @(posedge fclk);
        #1;
        chk("latency_capture", digVal, 16'h0001);
        hold(4'b1110, 7'h79, 14);

        // Full frame
        fd0 = fd_cnt;
        hold(4'b1110, 7'h12, 20);
        hold(4'b1101, 7'h30, 20);
        hold(4'b1011, 7'h24, 20);
        hold(4'b0111, 7'h40, 20);
        chk("frame_digVal", digVal, 16'h0235);
        chk("frame_pulses", 16'(fd_cnt - fd0), 16'd1);
        chk("frame_flags", 16'({digErr, digBlank}), 16'h00);

        // Glitch shorter than the stability window
        hold(4'b1110, 7'h00, 20);
        chk("glitch_pre", digVal, 16'h0238);
        hold(4'b1110, 7'h79, 2);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            hold(4'b1110, 7'h00, 1);
            if (digVal[3:0] !== 4'h8) bad++;
        end
        chk("glitch_nocapture", 16'(bad), 16'd0);
        chk("glitch_digVal", digVal, 16'h0238);

        // Blank then unrecognised pattern on digit 2
        hold(4'b1011, 7'h19, 20);
        chk("digit2_val", digVal, 16'h0438);
        hold(4'b1011, 7'h7F, 20);
        chk("blank_val", digVal, 16'h0438);
        chk("blank_flags", 16'({digErr, digBlank}), 16'h04);
        hold(4'b1011, 7'h55, 20);
        chk("err_val", digVal, 16'h0438);
        chk("err_flags", 16'({digErr, digBlank}), 16'h40);

        // Illegal anodes leave the digit registers and seen mask alone
        fd0 = fd_cnt;
        ae0 = ae_cnt;
        hold(4'b1100, 7'h12, 20);
        chk("illegal_pulses", 16'(ae_cnt - ae0), 16'd1);
        chk("illegal_val", digVal, 16'h0438);
        chk("illegal_flags", 16'({digErr, digBlank}), 16'h40);
        hold(4'b1101, 7'h79, 20);
        chk("mask_partial", 16'(fd_cnt - fd0), 16'd0);
        hold(4'b0111, 7'h02, 20);
        chk("mask_complete", 16'(fd_cnt - fd0), 16'd1);
        chk("mask_val", digVal, 16'h6418);

        // Reset mid-frame
        hold(4'b1110, 7'h30, 20);
        hold(4'b1101, 7'h24, 20);
        chk("midframe_val", digVal, 16'h6423);
        anode  = 4'b1111;
        segOut = 7'h7F;
        rst_n  = 1'b0;
        #2;
        chk("async_reset_val", digVal, 16'h0000);
        chk("async_reset_flags", 16'({digErr, digBlank}), 16'h00);
        @(posedge fclk);
        #1;
        rst_n = 1'b1;
        fd0 = fd_cnt;
        hold(4'b1011, 7'h79, 20);
        hold(4'b0111, 7'h79, 20);
        chk("postreset_noframe", 16'(fd_cnt - fd0), 16'd0);
        chk("postreset_val", digVal, 16'h1100);
        hold(4'b1110, 7'h79, 20);
        hold(4'b1101, 7'h79, 20);
        chk("postreset_frame", 16'(fd_cnt - fd0), 16'd1);
        chk("postreset_val2", digVal, 16'h1111);

        // Random hold periods against the model
        anode  = 4'b1111;
        segOut = 7'h7F;
        rst_n  = 1'b0;
        repeat (2) @(posedge fclk);
        #1;
        rst_n = 1'b1;
        model_reset();
        fd0 = fd_cnt;
        ae0 = ae_cnt;
        pa = 4'b1111;
        ps = 7'h7F;
        for (int cp = 0; cp < 12; cp++) begin
            for (int j = 0; j < 10; j++) begin
                do begin
                    r = $urandom_range(0, 9);
                    if (r < 7) begin
                        a = ~(4'b0001 << $urandom_range(0, 3));
                    end else if (r == 7) begin
                        a = 4'b1111;
                    end else begin
                        do a = 4'($urandom); while ($countones(a) > 2);
                    end
                    r = $urandom_range(0, 19);
                    if (r < 12) s = pat_tbl[$urandom_range(0, 9)];
                    else if (r < 15) s = 7'h7F;
                    else s = 7'($urandom);
                end while ({a, s} == {pa, ps});
                len = $urandom_range(1, STABLE + 6);
                hold(a, s, len);
                model_seg(a, s, len);
                pa = a;
                ps = s;
            end
            hold(4'b1111, 7'h7F, 20);
            pa = 4'b1111;
            ps = 7'h7F;
            chk("rand_digVal", digVal, {m_val[3], m_val[2], m_val[1], m_val[0]});
            chk("rand_digBlank", 16'(digBlank), 16'(m_blank));
            chk("rand_digErr", 16'(digErr), 16'(m_err));
            chk("rand_frameDone", 16'(fd_cnt - fd0), 16'(m_fd));
            chk("rand_anodeErr", 16'(ae_cnt - ae0), 16'(m_ae));
        end

        chk("pulse_exclusive", 16'(both_cnt), 16'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/seg_capture.md
# seg_capture

Seven-segment bus receiver. It samples the multiplexed active-low `anode`/`segOut` lines produced by the display controller and recovers the 4-bit value shown on each of the four digits. It also flags blanked digits, unrecognised segment patterns and illegal anode states. It sits beside the display controller on the same `fclk` domain and serves as a loopback checker and readback path for the keypad/display datapath.

## Interface
- `STABLE_CYCLES`, default 4: number of consecutive identical synchronised samples required before a capture (legal range 2..255).
- `fclk`, in, 1: single system clock; all state is on its rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `anode`, in, 4: digit enables, active-low; `anode[i]`=0 selects digit i.
- `segOut`, in, 7: segments, active-low, bit order `[6:0]` = g,f,e,d,c,b,a.
- `digVal`, out, 16: recovered digit values; `digVal[4i+3:4i]` belongs to digit i.
- `digBlank`, out, 4: bit i = 1 when digit i was last captured with all segments off.
- `digErr`, out, 4: bit i = 1 when digit i was last captured with an unrecognised pattern.
- `frameDone`, out, 1: one-cycle pulse when all four digits have been captured since the previous pulse.
- `anodeErr`, out, 1: one-cycle pulse when a stable pattern has two or more anodes low.

## Operation
- Input path: a 2-flop synchroniser on all 11 input bits, followed by a previous-sample register used for change detection.
- Stability counter: it clears when the synchronised {anode,segOut} differs from the previous sample and increments otherwise, saturating at `STABLE_CYCLES`.
- State machine:
  - `WAIT`: the pattern is changing. Go to `SETTLE` on the first unchanged sample.
  - `SETTLE`: any change returns to `WAIT`. When the counter reaches `STABLE_CYCLES`, evaluate the pattern and go to `HELD`.
  - `HELD`: no further captures. Any change returns to `WAIT`.
- Evaluation happens exactly once per stable period:
  - All anodes high: idle. No output changes.
  - Exactly one anode low (digit i): decode `segOut`.
  - Two or more anodes low: pulse `anodeErr`. No digit register changes.
- Decode table for `segOut` in hex, active-low:
  - 0x40→0, 0x79→1, 0x24→2, 0x30→3, 0x19→4, 0x12→5, 0x02→6, 0x78→7, 0x00→8, 0x10→9.
  - 0x7F is blank: set `digBlank[i]`=1 and `digErr[i]`=0; `digVal` for digit i is held.
  - Any other pattern: set `digErr[i]`=1 and `digBlank[i]`=0; `digVal` for digit i is held.
  - Valid digit: write `digVal` for digit i and clear both flags for i.
- Frame tracking: a 4-bit seen mask sets bit i on every single-anode capture, whether valid, blank or error.
  - When the mask becomes 4'b1111, `frameDone` pulses in that same cycle and the mask clears to 0.
  - Recapturing an already-seen digit is harmless; the mask bit is simply set again.
- Blink periods show all segments off on a selected digit. These are captured as blank, so the last valid value is retained.

## Timing
- Reset values:
  - `digVal`=16'h0000; `digBlank`, `digErr` = 4'b0000; `frameDone`, `anodeErr` = 0.
  - Synchroniser and previous-sample registers reset to all-ones (nothing selected), so no capture occurs out of reset.
  - State resets to `WAIT`; the seen mask resets to 0.
- Latency: inputs changing before edge 0 and then held constant produce the capture (register update or pulse) on edge `STABLE_CYCLES`+2.
- A glitch shorter than `STABLE_CYCLES` synchronised cycles never causes a capture.
- A pattern held indefinitely produces exactly one capture.
- Reset asserted mid-`SETTLE` or mid-frame clears everything immediately and asynchronously. After release, a full stable period is needed again.
- `frameDone` and `anodeErr` are mutually exclusive in any cycle; each is high for exactly one `fclk`.
- Outputs are registered and change only on `fclk` edges; nothing is combinational from the inputs.

## Test plan
- Reset: hold `rst_n`=0 with `anode`=4'b1110 and `segOut`=0x79 → all outputs 0. After release, `digVal[3:0]`=1 appears on edge `STABLE_CYCLES`+2 after release.
- Full frame: cycle anodes 1110/1101/1011/0111 with 0x12/0x30/0x24/0x40, each held 20 cycles → `digVal`=16'h0235, one `frameDone` pulse, `digErr`=`digBlank`=0.
- Glitch: anode 1110 with 0x00 held 20 cycles, then 0x79 for 2 cycles, then back to 0x00 (`STABLE_CYCLES`=4) → `digVal[3:0]`=8 and no capture of 1.
- Blank/error: digit 2 shows 0x19 (4), then 0x7F, then 0x55, each held 20 cycles → `digVal[11:8]`=4 throughout; `digBlank[2]`=1, then `digErr[2]`=1 with `digBlank[2]`=0.
- Illegal anodes: `anode`=4'b1100 held 20 cycles → exactly one `anodeErr` pulse; `digVal`, flags and seen mask unchanged.
- Reset mid-frame: capture digits 0 and 1, pulse `rst_n` low, then capture digits 2 and 3 → no `frameDone`, because the mask was cleared and only 2 of 4 digits have been seen.
